sr_ff_bank: RTL and testbench
=============================

SR_FF_BANK -- requirements
Module: sr_ff_bank

Interface
REQ-001 Parameter WIDTH, default 4: number of independent SR channels, legal range 1..32.
REQ-002 Parameter MODE, default 0: S=R=1 resolution; 0 reset-dominant, 1 set-dominant, 2 hold, 3 toggle.
REQ-003 Parameter CNT_W, default 8: conflict counter width, legal range 1..16.
REQ-004 Parameter INIT, default 0 (WIDTH bits): per-channel Q value loaded on reset.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 en  in  1  clock enable for channel state and conflict counting.
REQ-008 S  in  WIDTH  per-channel set request.
REQ-009 R  in  WIDTH  per-channel reset request.
REQ-010 clr_cnt  in  1  synchronous clear of the conflict counter.
REQ-011 Q  out  WIDTH  registered channel state.
REQ-012 Qn  out  WIDTH  complement of Q.
REQ-013 rise  out  WIDTH  one-cycle pulse when channel Q went 0->1.
REQ-014 fall  out  WIDTH  one-cycle pulse when channel Q went 1->0.
REQ-015 conflict  out  1  registered flag: previous enabled cycle had any S[i]&R[i].
REQ-016 conflict_cnt  out  CNT_W  saturating count of enabled cycles with any conflict.

Function
REQ-017 Per channel with en=1, the edge SHALL apply: S=1,R=0 -> Q=1; S=0,R=1 -> Q=0; S=0,R=0 -> hold.
REQ-018 With en=1 and S[i]=R[i]=1, Q[i] SHALL follow MODE: 0 -> 0, 1 -> 1, 2 -> hold, 3 -> ~Q[i].
REQ-019 With en=0, Q SHALL hold, rise/fall SHALL be 0, conflict SHALL be 0, counter SHALL hold.
REQ-020 Latency: S/R sampled at edge k SHALL be visible on Q at edge k; one clock of latency, no combinational S/R->Q path.
REQ-021 Qn SHALL equal ~Q in every cycle; the invalid Q=Qn state SHALL be unreachable.
REQ-022 rise[i]/fall[i] SHALL be registered at the same edge as the Q change and last exactly one cycle.
REQ-023 A hold or same-value write SHALL produce no rise/fall pulse.
REQ-024 Counter: +1 per enabled cycle with |(S&R), regardless of how many channels conflict.
REQ-025 Counter SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 clr_cnt=1 SHALL force counter to 0 at the next edge, winning over a simultaneous increment; clr_cnt SHALL act independent of en.
REQ-027 Channels SHALL be fully independent; activity on one never affects another's Q, rise or fall.

Reset
REQ-028 rst=1 at an edge SHALL set Q=INIT, Qn=~INIT, rise=0, fall=0, conflict=0, conflict_cnt=0.
REQ-029 rst SHALL take precedence over en, S, R and clr_cnt.
REQ-030 Reset mid-operation SHALL not generate rise/fall pulses for the INIT load, including in the first cycle after release.

Structure
REQ-031 Shared package sr_pkg SHALL hold MODE constants MODE_RST_DOM=0, MODE_SET_DOM=1, MODE_HOLD=2, MODE_TOGGLE=3.
REQ-032 One sub-module sr_ff_cell (single channel: Q, rise, fall) SHALL be instantiated WIDTH times via generate.
REQ-033 Conflict detection and saturating counter SHALL live in sr_ff_bank top level.

Verification (WIDTH=4, CNT_W=2, INIT=4'b0000 unless stated)
REQ-034 Reset then S=4'b0101,R=0,en=1 one cycle -> Q=0101, Qn=1010, rise=0101 for one cycle, then rise=0.
REQ-035 From Q=1111, S=0,R=4'b0011 -> Q=1100, fall=0011 one cycle; S=R=0 next -> Q held, no pulses.
REQ-036 S=R=4'b1111 for one cycle from Q=0101 under MODE 0/1/2/3 -> Q=0000/1111/0101/1010; conflict=1 next cycle.
REQ-037 S=R=4'b0001 held 5 enabled cycles -> conflict_cnt 1,2,3,3,3; clr_cnt with a conflict -> 0.
REQ-038 en=0 with S=4'b1111 -> Q, counter unchanged, rise=0; INIT=4'b1010, rst mid-run -> Q=1010, no pulses.

Source files
------------

// File: rtl/sr_pkg.sv
// Shared constants for the SR flip-flop bank.
// MODE_* select how a channel resolves a simultaneous set and reset request.
package sr_pkg;

  localparam int unsigned MODE_RST_DOM = 0;  // S=R=1 clears Q
  localparam int unsigned MODE_SET_DOM = 1;  // S=R=1 sets Q
  localparam int unsigned MODE_HOLD    = 2;  // S=R=1 keeps Q
  localparam int unsigned MODE_TOGGLE  = 3;  // S=R=1 inverts Q

endpackage

// File: rtl/sr_ff_cell.sv
// Single SR channel: registered state plus one-cycle rise/fall edge pulses.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   en         clock enable; when low the state holds and no pulses are produced
//   s, r       set / reset requests
//   q          registered channel state
//   rise, fall one-cycle pulses registered on the same edge as a 0->1 / 1->0 change of q
module sr_ff_cell
  import sr_pkg::*;
#(
  parameter int unsigned MODE = MODE_RST_DOM,
  parameter logic        INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic s,
  input  logic r,
  output logic q,
  output logic rise,
  output logic fall
);

  logic q_q, q_d;
  logic rise_q, fall_q;

  always_comb begin
    q_d = q_q;
    unique case ({s, r})
      2'b00: q_d = q_q;
      2'b10: q_d = 1'b1;
      2'b01: q_d = 1'b0;
      2'b11: begin
        case (MODE)
          MODE_RST_DOM: q_d = 1'b0;
          MODE_SET_DOM: q_d = 1'b1;
          MODE_TOGGLE:  q_d = ~q_q;
          default:      q_d = q_q;
        endcase
      end
    endcase
  end

  // Reset loads INIT without pulses; the first post-reset edge compares against INIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= INIT;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else if (en) begin
      q_q    <= q_d;
      rise_q <= ~q_q & q_d;
      fall_q <= q_q & ~q_d;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end
  end

  assign q    = q_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of WIDTH independent SR flip-flops with conflict detection and a
// saturating conflict counter.
// Ports:
//   clk, rst      clock and synchronous active-high reset (wins over everything)
//   en            clock enable for channel state and conflict counting
//   S, R          per-channel set / reset requests
//   clr_cnt       synchronous counter clear, independent of en
//   Q, Qn         registered channel state and its complement
//   rise, fall    per-channel one-cycle edge pulses
//   conflict      previous enabled cycle had some S[i]&R[i]
//   conflict_cnt  saturating count of enabled cycles with any conflict
module sr_ff_bank
  import sr_pkg::*;
#(
  parameter int unsigned           WIDTH = 4,
  parameter int unsigned           MODE  = MODE_RST_DOM,
  parameter int unsigned           CNT_W = 8,
  parameter logic [WIDTH-1:0]      INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_ff_cell #(
      .MODE (MODE),
      .INIT (INIT[i])
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .s    (S[i]),
      .r    (R[i]),
      .q    (Q[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  // Complement taken from the same register, so Q == Qn can never be observed.
  assign Qn = ~Q;

  logic             any_conflict;
  logic             conflict_q, conflict_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign any_conflict = |(S & R);

  always_comb begin
    conflict_d = en & any_conflict;
    cnt_d      = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (en && any_conflict && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
    end
  end

  assign conflict     = conflict_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Scoreboard bench: five banks (MODE 0..3 with INIT=0, plus MODE 0 with
// INIT=1010) share one stimulus stream. The driver predicts each edge with a
// vector-level reference model and queues the result; the monitor pops one
// entry per clock edge and compares every output of every bank.
module tb_sr_ff_bank;

  localparam int NI = 5;

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] qn;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       conflict;
    logic [1:0] cnt;
  } exp_t;
  typedef exp_t [NI-1:0] exp_vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] s_in = '0;
  logic [3:0] r_in = '0;
  logic       clr = 1'b0;

  logic [3:0] q_w    [NI];
  logic [3:0] qn_w   [NI];
  logic [3:0] rise_w [NI];
  logic [3:0] fall_w [NI];
  logic       conf_w [NI];
  logic [1:0] cnt_w  [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sr_ff_bank #(
      .WIDTH (4),
      .MODE  ((g < 4) ? g : 0),
      .CNT_W (2),
      .INIT  ((g == 4) ? 4'b1010 : 4'b0000)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .S            (s_in),
      .R            (r_in),
      .clr_cnt      (clr),
      .Q            (q_w[g]),
      .Qn           (qn_w[g]),
      .rise         (rise_w[g]),
      .fall         (fall_w[g]),
      .conflict     (conf_w[g]),
      .conflict_cnt (cnt_w[g])
    );
  end

  int checks = 0;
  int errors = 0;
  exp_vec_t sb[$];

  // Reference model state
  logic [3:0] mq [NI];
  int         mcnt = 0;

  function automatic int mode_of(int i);
    return (i < 4) ? i : 0;
  endfunction

  function automatic logic [3:0] init_of(int i);
    return (i == 4) ? 4'b1010 : 4'b0000;
  endfunction

  task automatic check(string name, int inst, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, inst, act, expv, $time);
    end
  endtask

  // Apply one cycle of stimulus and queue the predicted post-edge outputs.
  task automatic step(logic rs, logic e, logic [3:0] s, logic [3:0] r, logic c);
    exp_vec_t   ev;
    logic [3:0] nxt, res;
    logic       any;
    @(negedge clk);
    rst = rs; en = e; s_in = s; r_in = r; clr = c;
    any = |(s & r);
    if (rs) mcnt = 0;
    else if (c) mcnt = 0;
    else if (e && any) mcnt = (mcnt + 1 > 3) ? 3 : mcnt + 1;
    for (int i = 0; i < NI; i++) begin
      if (rs) begin
        nxt = init_of(i);
        ev[i].rise = '0;
        ev[i].fall = '0;
        ev[i].conflict = 1'b0;
      end else if (e) begin
        case (mode_of(i))
          0: res = 4'b0000;
          1: res = 4'b1111;
          2: res = mq[i];
          default: res = ~mq[i];
        endcase
        nxt = (s & ~r) | (~s & ~r & mq[i]) | (s & r & res);
        ev[i].rise = ~mq[i] & nxt;
        ev[i].fall = mq[i] & ~nxt;
        ev[i].conflict = any;
      end else begin
        nxt = mq[i];
        ev[i].rise = '0;
        ev[i].fall = '0;
        ev[i].conflict = 1'b0;
      end
      mq[i] = nxt;
      ev[i].q = nxt;
      ev[i].qn = ~nxt;
      ev[i].cnt = 2'(mcnt);
    end
    sb.push_back(ev);
  endtask

  // Monitor: one queued prediction per clock edge once the driver has started.
  initial begin
    exp_vec_t ev;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        ev = sb.pop_front();
        for (int i = 0; i < NI; i++) begin
          check("Q", i, 32'(q_w[i]), 32'(ev[i].q));
          check("Qn", i, 32'(qn_w[i]), 32'(ev[i].qn));
          check("rise", i, 32'(rise_w[i]), 32'(ev[i].rise));
          check("fall", i, 32'(fall_w[i]), 32'(ev[i].fall));
          check("conflict", i, 32'(conf_w[i]), 32'(ev[i].conflict));
          check("conflict_cnt", i, 32'(cnt_w[i]), 32'(ev[i].cnt));
        end
      end
    end
  end

  // Hand-derived spot checks, sampled just after the monitor for the same edge.
  task automatic spot(string name, int inst, logic [31:0] act_sel, logic [31:0] expv);
    check(name, inst, act_sel, expv);
  endtask

  initial begin
    int wait_cycles;
    for (int i = 0; i < NI; i++) mq[i] = 'x;
    step(1, 0, 4'b0000, 4'b0000, 0);
    step(1, 1, 4'b1111, 4'b0000, 1);

    // Set two channels from reset, then idle.
    step(0, 1, 4'b0101, 4'b0000, 0);
    @(posedge clk); #2;
    spot("set_q", 0, 32'(q_w[0]), 32'h5);
    spot("set_rise", 0, 32'(rise_w[0]), 32'h5);
    step(0, 1, 4'b0000, 4'b0000, 0);
    @(posedge clk); #2;
    spot("rise_clears", 0, 32'(rise_w[0]), 32'h0);

    // All ones, then reset the low pair, then hold.
    step(0, 1, 4'b1111, 4'b0000, 0);
    step(0, 1, 4'b0000, 4'b0011, 0);
    @(posedge clk); #2;
    spot("reset_q", 1, 32'(q_w[1]), 32'hC);
    spot("reset_fall", 1, 32'(fall_w[1]), 32'h3);
    step(0, 1, 4'b0000, 4'b0000, 0);

    // Bring every bank to 0101, then a full conflict.
    step(0, 1, 4'b0101, 4'b1010, 0);
    step(0, 1, 4'b1111, 4'b1111, 0);
    @(posedge clk); #2;
    spot("mode0_q", 0, 32'(q_w[0]), 32'h0);
    spot("mode1_q", 1, 32'(q_w[1]), 32'hF);
    spot("mode2_q", 2, 32'(q_w[2]), 32'h5);
    spot("mode3_q", 3, 32'(q_w[3]), 32'hA);
    spot("conflict_flag", 3, 32'(conf_w[3]), 32'h1);

    // Counter saturation and clear-over-increment.
    step(0, 1, 4'b0000, 4'b0000, 1);
    for (int k = 0; k < 5; k++) step(0, 1, 4'b0001, 4'b0001, 0);
    @(posedge clk); #2;
    spot("cnt_sat", 0, 32'(cnt_w[0]), 32'h3);
    step(0, 1, 4'b0001, 4'b0001, 1);
    @(posedge clk); #2;
    spot("cnt_clr", 0, 32'(cnt_w[0]), 32'h0);

    // Disabled set attempt, then reset mid-run into INIT=1010.
    step(0, 0, 4'b1111, 4'b0000, 0);
    step(1, 1, 4'b1111, 4'b0000, 0);
    step(0, 0, 4'b0000, 4'b0000, 0);
    @(posedge clk); #2;
    spot("init_q", 4, 32'(q_w[4]), 32'hA);
    spot("init_rise", 4, 32'(rise_w[4]), 32'h0);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
           4'($urandom), 4'($urandom), ($urandom_range(0, 9) == 0));
    end
    step(0, 0, 4'b0000, 4'b0000, 0);

    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
